// File: rtl/data_stack.sv
// data_stack: DEPTH x 16-bit hardware operand stack for the push subsystem.
// Exposes top-of-stack (aWire) and next-of-stack (bWire) combinationally from
// registered state, flags full/empty, and keeps sticky Overflow/Underflow flags.
// Optional feature macro: DATA_STACK_PEEK_EN adds PeekIdx/PeekVal random read.
module data_stack #(
    parameter int DEPTH = 16,
    parameter int SPW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      StackOp,
    input  logic [15:0]     PushValw,
    input  logic            ErrClr,
`ifdef DATA_STACK_PEEK_EN
    input  logic [SPW-1:0]  PeekIdx,
    output logic [15:0]     PeekVal,
`endif
    output logic [15:0]     aWire,
    output logic [15:0]     bWire,
    output logic [SPW:0]    count,
    output logic            full,
    output logic            empty,
    output logic            Overflow,
    output logic            Underflow
);

    // Operation interface: there is no valid/ready handshake. StackOp is taken
    // on every rising clk edge; NOP is the idle code. PushValw is sampled only
    // on PUSH/BINOP edges, so it may be X in any other cycle. Illegal ops
    // (PUSH while full, POP/BINOP without enough operands) leave the stack
    // untouched and set the matching sticky flag instead.
    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_PUSH  = 2'b01,
        OP_POP   = 2'b10,
        OP_BINOP = 2'b11
    } stackOpT;

    localparam logic [SPW:0]   CNT_ONE  = (SPW+1)'(1);
    localparam logic [SPW:0]   CNT_TWO  = (SPW+1)'(2);
    localparam logic [SPW:0]   CNT_FULL = (SPW+1)'(DEPTH);
    localparam logic [SPW-1:0] IDX_ONE  = SPW'(1);
    localparam logic [SPW-1:0] IDX_TWO  = SPW'(2);

    stackOpT        opDec;
    logic [15:0]    mem [DEPTH];

    logic [SPW-1:0] ptrLow;
    logic [SPW-1:0] topIdx;
    logic [SPW-1:0] nosIdx;
    logic           isFull;
    logic           isEmpty;
    logic           hasTwo;

    logic           doWrite;
    logic [SPW-1:0] wrIdx;
    logic [SPW:0]   nextCount;
    logic           ovfSet;
    logic           unfSet;

    assign opDec = stackOpT'(StackOp);

    // Pointer arithmetic is done on the low SPW bits; when count==DEPTH the low
    // bits are zero and subtracting one lands on DEPTH-1, which is the TOS.
    // Results for count<1 or count<2 are masked by isEmpty/hasTwo below.
    always_comb begin
        ptrLow  = count[SPW-1:0];
        topIdx  = ptrLow - IDX_ONE;
        nosIdx  = ptrLow - IDX_TWO;
        isFull  = (count == CNT_FULL);
        isEmpty = (count == '0);
        hasTwo  = (count >= CNT_TWO);
    end

    // Decode the requested operation into a write, a count update and error events.
    always_comb begin
        doWrite   = 1'b0;
        wrIdx     = ptrLow;
        nextCount = count;
        ovfSet    = 1'b0;
        unfSet    = 1'b0;
        case (opDec)
            OP_PUSH: begin
                if (isFull) begin
                    ovfSet = 1'b1;
                end else begin
                    doWrite   = 1'b1;
                    wrIdx     = ptrLow;
                    nextCount = count + CNT_ONE;
                end
            end
            OP_POP: begin
                if (isEmpty) begin
                    unfSet = 1'b1;
                end else begin
                    nextCount = count - CNT_ONE;
                end
            end
            OP_BINOP: begin
                // Result overwrites NOS and the old TOS is dropped, so a
                // BINOP can never overflow and is legal on a full stack.
                if (!hasTwo) begin
                    unfSet = 1'b1;
                end else begin
                    doWrite   = 1'b1;
                    wrIdx     = nosIdx;
                    nextCount = count - CNT_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Entry storage: cleared on reset, one entry written per PUSH/BINOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doWrite) begin
            mem[wrIdx] <= PushValw;
        end
    end

    // Occupancy counter; saturation is guaranteed by the decode, never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            count <= nextCount;
        end
    end

    // Sticky error flags: a same-cycle error event wins over ErrClr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            Overflow  <= ovfSet | (Overflow  & ~ErrClr);
            Underflow <= unfSet | (Underflow & ~ErrClr);
        end
    end

    // Top/next-of-stack views, forced to zero when the entries are not valid.
    always_comb begin
        aWire = isEmpty ? 16'h0000 : mem[topIdx];
        bWire = hasTwo  ? mem[nosIdx] : 16'h0000;
        full  = isFull;
        empty = isEmpty;
    end

`ifdef DATA_STACK_PEEK_EN
    logic           peekInRange;
    logic [SPW-1:0] peekMemIdx;

    // Random read at depth PeekIdx below TOS; zero beyond the valid entries.
    always_comb begin
        peekInRange = ({1'b0, PeekIdx} < count);
        peekMemIdx  = topIdx - PeekIdx;
        PeekVal     = peekInRange ? mem[peekMemIdx] : 16'h0000;
    end
`endif

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack: directed vector table, hand-written corner sequences and a
// randomized run checked against a queue-based model of the operand stack.
module tb_data_stack;

    localparam int DEPTH = 16;
    localparam int SPW   = 4;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] PUSH  = 2'b01;
    localparam logic [1:0] POP   = 2'b10;
    localparam logic [1:0] BINOP = 2'b11;

    logic            clk;
    logic            reset;
    logic [1:0]      StackOp;
    logic [15:0]     PushValw;
    logic            ErrClr;
    logic [15:0]     aWire;
    logic [15:0]     bWire;
    logic [SPW:0]    count;
    logic            full;
    logic            empty;
    logic            Overflow;
    logic            Underflow;
`ifdef DATA_STACK_PEEK_EN
    logic [SPW-1:0]  PeekIdx;
    logic [15:0]     PeekVal;
`endif

    int total;
    int bad;

    // Reference model state.
    logic [15:0] mdl_q[$];
    logic        mdl_ovf;
    logic        mdl_unf;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] val;
        logic        clr;
        logic [15:0] ea;
        logic [15:0] eb;
        int          ec;
        logic        eovf;
        logic        eunf;
    } vec_t;

    vec_t vecs[11];

    data_stack #(.DEPTH(DEPTH), .SPW(SPW)) dut (
        .clk       (clk),
        .reset     (reset),
        .StackOp   (StackOp),
        .PushValw  (PushValw),
        .ErrClr    (ErrClr),
`ifdef DATA_STACK_PEEK_EN
        .PeekIdx   (PeekIdx),
        .PeekVal   (PeekVal),
`endif
        .aWire     (aWire),
        .bWire     (bWire),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Check every observable output against explicit expectations.
    task automatic check_all(input string tag, input logic [15:0] ea, input logic [15:0] eb,
                             input int ec, input logic eovf, input logic eunf);
        check({tag, ".aWire"},     32'(aWire),     32'(ea));
        check({tag, ".bWire"},     32'(bWire),     32'(eb));
        check({tag, ".count"},     32'(count),     32'(ec));
        check({tag, ".full"},      32'(full),      32'(ec == DEPTH));
        check({tag, ".empty"},     32'(empty),     32'(ec == 0));
        check({tag, ".Overflow"},  32'(Overflow),  32'(eovf));
        check({tag, ".Underflow"}, 32'(Underflow), 32'(eunf));
    endtask

    // Drive one op at the falling edge, sample #1 after the following rising edge.
    task automatic do_op(input logic [1:0] op, input logic [15:0] val, input logic clr);
        @(negedge clk);
        StackOp  = op;
        PushValw = val;
        ErrClr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        @(negedge clk);
        StackOp  = NOP;
        PushValw = 16'hxxxx;
        ErrClr   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        @(negedge clk);
        reset = 1'b1;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;
    endtask

    // Model step from the stack rules, then compare against the DUT.
    task automatic model_op(input logic [1:0] op, input logic [15:0] val, input logic clr);
        logic ovf_ev;
        logic unf_ev;
        logic [15:0] ea;
        logic [15:0] eb;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        case (op)
            PUSH: if (mdl_q.size() == DEPTH) ovf_ev = 1'b1; else mdl_q.push_back(val);
            POP: if (mdl_q.size() == 0) unf_ev = 1'b1; else void'(mdl_q.pop_back());
            BINOP: begin
                if (mdl_q.size() < 2) unf_ev = 1'b1;
                else begin
                    void'(mdl_q.pop_back());
                    void'(mdl_q.pop_back());
                    mdl_q.push_back(val);
                end
            end
            default: ;
        endcase
        mdl_ovf = ovf_ev | (mdl_ovf & ~clr);
        mdl_unf = unf_ev | (mdl_unf & ~clr);
        do_op(op, val, clr);
        ea = (mdl_q.size() >= 1) ? mdl_q[mdl_q.size()-1] : 16'h0000;
        eb = (mdl_q.size() >= 2) ? mdl_q[mdl_q.size()-2] : 16'h0000;
        check_all("rand", ea, eb, mdl_q.size(), mdl_ovf, mdl_unf);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        StackOp  = NOP;
        PushValw = 16'h0000;
        ErrClr   = 1'b0;
`ifdef DATA_STACK_PEEK_EN
        PeekIdx  = '0;
`endif
        mdl_ovf  = 1'b0;
        mdl_unf  = 1'b0;

        // Directed table: op, val, clr, aWire, bWire, count, Overflow, Underflow.
        vecs[0]  = '{PUSH,  16'h00ff, 1'b0, 16'h00ff, 16'h0000, 1, 1'b0, 1'b0};
        vecs[1]  = '{PUSH,  16'hffdd, 1'b0, 16'hffdd, 16'h00ff, 2, 1'b0, 1'b0};
        vecs[2]  = '{BINOP, 16'h7fcd, 1'b0, 16'h7fcd, 16'h0000, 1, 1'b0, 1'b0};
        vecs[3]  = '{BINOP, 16'h1234, 1'b0, 16'h7fcd, 16'h0000, 1, 1'b0, 1'b1};
        vecs[4]  = '{NOP,   16'h0000, 1'b1, 16'h7fcd, 16'h0000, 1, 1'b0, 1'b0};
        vecs[5]  = '{POP,   16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        vecs[6]  = '{POP,   16'h0000, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[7]  = '{POP,   16'h0000, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[8]  = '{NOP,   16'h0000, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};
        vecs[9]  = '{BINOP, 16'h5555, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, 1'b1};
        vecs[10] = '{NOP,   16'h0000, 1'b1, 16'h0000, 16'h0000, 0, 1'b0, 1'b0};

        // Reset state.
        #12;
        check_all("reset", 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_all("post_reset", 16'h0000, 16'h0000, 0, 1'b0, 1'b0);

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].op, vecs[i].val, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].ec,
                      vecs[i].eovf, vecs[i].eunf);
        end

        // Fill to full, then overflow, BINOP on full, and error-vs-clear priority.
        for (int i = 1; i <= DEPTH; i++) begin
            do_op(PUSH, 16'(i), 1'b0);
        end
        check_all("filled", 16'h0010, 16'h000f, 16, 1'b0, 1'b0);
        do_op(PUSH, 16'hdead, 1'b0);
        check_all("overflow", 16'h0010, 16'h000f, 16, 1'b1, 1'b0);
        do_op(BINOP, 16'hbeef, 1'b0);
        check_all("binop_full", 16'hbeef, 16'h000e, 15, 1'b1, 1'b0);
        do_op(NOP, 16'h0000, 1'b1);
        check_all("ovf_clear", 16'hbeef, 16'h000e, 15, 1'b0, 1'b0);
        do_op(PUSH, 16'h0a0a, 1'b0);
        do_op(PUSH, 16'h0b0b, 1'b1);
        check_all("ovf_beats_clr", 16'h0a0a, 16'hbeef, 16, 1'b1, 1'b0);
        go_idle();

        // Reset asserted mid-cycle with three entries: contents vanish before the next edge.
        apply_reset();
        do_op(PUSH, 16'h0001, 1'b0);
        do_op(PUSH, 16'h0002, 1'b0);
        do_op(PUSH, 16'h0003, 1'b0);
        check_all("three", 16'h0003, 16'h0002, 3, 1'b0, 1'b0);
`ifdef DATA_STACK_PEEK_EN
        PeekIdx = 4'd2;
        #1;
        check("peek2", 32'(PeekVal), 32'h1);
        PeekIdx = 4'd3;
        #1;
        check("peek3", 32'(PeekVal), 32'h0);
        PeekIdx = 4'd0;
        #1;
        check("peek0", 32'(PeekVal), 32'h3);
`endif
        go_idle();
        #2;
        reset = 1'b0;
        #1;
        check_all("async_reset", 16'h0000, 16'h0000, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        mdl_q.delete();
        mdl_ovf = 1'b0;
        mdl_unf = 1'b0;

        // Randomized run against the queue model; push-heavy to reach full often.
        for (int n = 0; n < 600; n++) begin
            logic [1:0] op;
            int r;
            r = $urandom_range(0, 99);
            if (n >= 300) r = (r + 40) % 100;
            if (r < 45)      op = PUSH;
            else if (r < 70) op = POP;
            else if (r < 90) op = BINOP;
            else             op = NOP;
            model_op(op, 16'($urandom), ($urandom_range(0, 9) == 0));
        end
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
